imem_responder: RTL and testbench

Instruction-memory responder: the memory side of the fetch request/response pair, receiving `instr_req_type` and returning `instr_resp_type`. It accepts a two-word fetch request (instr0 and instr1 byte addresses), waits a fixed programmable latency, then returns both instruction words with a single-cycle `ready` pulse. It sits between the fetch stage and the instruction storage, and supports a flush from branch recovery and a backdoor write port for program preload.

---
 rtl/imem_responder_pkg.sv | 34 +++
 rtl/imem_array.sv | 41 ++++
 rtl/imem_responder.sv | 100 ++++++++++
 tb/tb_imem_responder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_responder_pkg.sv
// Shared fetch-interface types and constants for the instruction-memory responder.
package imem_responder_pkg;

  localparam int ADDR_WIDTH     = 32;
  localparam int XLEN_WIDTH     = 32;
  localparam int IMEM_LAT_WIDTH = 4;

  localparam logic [XLEN_WIDTH-1:0] INSTRUCTION_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] instr0;
    logic [ADDR_WIDTH-1:0] instr1;
    logic                  valid;
  } instr_req_type;

  typedef struct packed {
    logic [XLEN_WIDTH-1:0] instr0;
    logic [XLEN_WIDTH-1:0] instr1;
    logic                  ready;
  } instr_resp_type;

  typedef enum logic [1:0] {
    IMEM_IDLE,
    IMEM_WAIT,
    IMEM_RESP
  } imem_state_type;

  // A slot faults when it is not word aligned or lies past the end of the array.
  function automatic logic imem_addr_fault(input logic [ADDR_WIDTH-1:0] addr,
                                           input int unsigned           depth_words);
    return (addr[1:0] != 2'b00) || ((addr >> 2) >= depth_words);
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, two combinational read ports
// that substitute a NOP for misaligned or out-of-range addresses.
module imem_array
  import imem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [XLEN_WIDTH-1:0] wr_data_i,
  input  logic [ADDR_WIDTH-1:0] rd0_addr_i,
  input  logic [ADDR_WIDTH-1:0] rd1_addr_i,
  output logic [XLEN_WIDTH-1:0] rd0_data_o,
  output logic [XLEN_WIDTH-1:0] rd1_data_o,
  output logic                  rd0_fault_o,
  output logic                  rd1_fault_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  logic [XLEN_WIDTH-1:0] mem_q [DEPTH_WORDS];
  logic                  wr_in_range;

  // Backdoor writes ignore the byte offset; only the word range is checked.
  assign wr_in_range = ((wr_addr_i >> 2) < DEPTH_WORDS);

  always_ff @(posedge clk) begin
    if (wr_en_i && wr_in_range) begin
      mem_q[wr_addr_i[IDX_W+1:2]] <= wr_data_i;
    end
  end

  always_comb begin
    rd0_fault_o = imem_addr_fault(rd0_addr_i, DEPTH_WORDS);
    rd1_fault_o = imem_addr_fault(rd1_addr_i, DEPTH_WORDS);
    rd0_data_o  = rd0_fault_o ? INSTRUCTION_NOP : mem_q[rd0_addr_i[IDX_W+1:2]];
    rd1_data_o  = rd1_fault_o ? INSTRUCTION_NOP : mem_q[rd1_addr_i[IDX_W+1:2]];
  end

endmodule

// File: rtl/imem_responder.sv
// Fixed-latency instruction-memory responder for two-word fetch requests.
// Define IMEM_ERR_EN to add the per-slot err_o fault flags.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  instr_req_type         req_i,
  output instr_resp_type        resp_o,
  input  logic                  flush_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [XLEN_WIDTH-1:0] wr_data_i
`ifdef IMEM_ERR_EN
  ,
  output logic [1:0]            err_o
`endif
);

  localparam logic [IMEM_LAT_WIDTH-1:0] CNT_INIT = IMEM_LAT_WIDTH'(LATENCY - 1);
  localparam logic [IMEM_LAT_WIDTH-1:0] CNT_ONE  = IMEM_LAT_WIDTH'(1);

  imem_state_type              state_q;
  logic [IMEM_LAT_WIDTH-1:0]   cnt_q;
  logic [ADDR_WIDTH-1:0]       addr0_q;
  logic [ADDR_WIDTH-1:0]       addr1_q;

  logic [XLEN_WIDTH-1:0]       rd0_data;
  logic [XLEN_WIDTH-1:0]       rd1_data;
  logic [1:0]                  fault;
  logic                        ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IMEM_IDLE;
      cnt_q   <= '0;
      addr0_q <= '0;
      addr1_q <= '0;
    end else if (flush_i) begin
      state_q <= IMEM_IDLE;
    end else begin
      unique case (state_q)
        IMEM_IDLE: begin
          if (req_i.valid) begin
            addr0_q <= req_i.instr0;
            addr1_q <= req_i.instr1;
            cnt_q   <= CNT_INIT;
            state_q <= (LATENCY == 1) ? IMEM_RESP : IMEM_WAIT;
          end
        end
        IMEM_WAIT: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q <= IMEM_RESP;
          end
        end
        IMEM_RESP: state_q <= IMEM_IDLE;
        default:   state_q <= IMEM_IDLE;
      endcase
    end
  end

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk         (clk),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i),
    .rd0_addr_i  (addr0_q),
    .rd1_addr_i  (addr1_q),
    .rd0_data_o  (rd0_data),
    .rd1_data_o  (rd1_data),
    .rd0_fault_o (fault[0]),
    .rd1_fault_o (fault[1])
  );

  // Flush kills the response in the same cycle, so ready cannot be a pure flop.
  assign ready = (state_q == IMEM_RESP) && !flush_i;

  always_comb begin
    resp_o = '0;
    if (ready) begin
      resp_o.instr0 = rd0_data;
      resp_o.instr1 = rd1_data;
      resp_o.ready  = 1'b1;
    end
  end

`ifdef IMEM_ERR_EN
  assign err_o = ready ? fault : 2'b00;
`else
  logic unused_fault;
  assign unused_fault = ^fault;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder at LATENCY 2, 3 and 1 (optionally with IMEM_ERR_EN).
module tb_imem_responder;
  import imem_responder_pkg::*;

  localparam int NDUT = 3;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT0 = 2;
  localparam int unsigned LAT1 = 3;
  localparam int unsigned LAT2 = 1;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  flush = 1'b0;
  logic                  wr_en = 1'b0;
  logic [ADDR_WIDTH-1:0] wr_addr = '0;
  logic [XLEN_WIDTH-1:0] wr_data = '0;
  instr_req_type         req  [NDUT];
  instr_resp_type        resp [NDUT];
`ifdef IMEM_ERR_EN
  logic [1:0]            err  [NDUT];
`endif

  typedef struct {
    logic [31:0] i0;
    logic [31:0] i1;
    logic [1:0]  err;
    int          cyc;
  } exp_t;

  exp_t        sb [NDUT][$];
  logic [31:0] model_mem [DEPTH];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .req_i(req[0]), .resp_o(resp[0]), .flush_i(flush),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data)
`ifdef IMEM_ERR_EN
    , .err_o(err[0])
`endif
  );

  imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .req_i(req[1]), .resp_o(resp[1]), .flush_i(flush),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data)
`ifdef IMEM_ERR_EN
    , .err_o(err[1])
`endif
  );

  imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .req_i(req[2]), .resp_o(resp[2]), .flush_i(flush),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data)
`ifdef IMEM_ERR_EN
    , .err_o(err[2])
`endif
  );

  function automatic int lat(input int d);
    case (d)
      0:       return int'(LAT0);
      1:       return int'(LAT1);
      default: return int'(LAT2);
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic slot_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (slot_fault(a)) return 32'h0000_0013;
    return model_mem[a[11:2]];
  endfunction

  // Response monitor: every cycle either a scheduled response or idle zeros.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < NDUT; d++) begin
      if (resp[d].ready) begin
        if (sb[d].size() == 0) begin
          check_eq($sformatf("unexp_rdy%0d", d), 64'(resp[d].ready), 64'd0);
        end else begin
          e = sb[d].pop_front();
          check_eq($sformatf("rdy_cyc%0d", d), 64'(cyc), 64'(e.cyc));
          check_eq($sformatf("instr0_%0d", d), 64'(resp[d].instr0), 64'(e.i0));
          check_eq($sformatf("instr1_%0d", d), 64'(resp[d].instr1), 64'(e.i1));
`ifdef IMEM_ERR_EN
          check_eq($sformatf("err%0d", d), 64'(err[d]), 64'(e.err));
`endif
        end
      end else begin
        check_eq($sformatf("idle_zero%0d", d), {resp[d].instr0, resp[d].instr1}, 64'd0);
`ifdef IMEM_ERR_EN
        check_eq($sformatf("idle_err%0d", d), 64'(err[d]), 64'd0);
`endif
        if (sb[d].size() != 0 && sb[d][0].cyc <= cyc) begin
          check_eq($sformatf("missed_rdy%0d", d), 64'(resp[d].ready), 64'd1);
          e = sb[d].pop_front();
        end
      end
    end
  end

  task automatic issue(input int d, input logic [31:0] a0, input logic [31:0] a1,
                       input bit push, input logic [31:0] e0, input logic [31:0] e1);
    @(negedge clk);
    req[d].instr0 = a0;
    req[d].instr1 = a1;
    req[d].valid  = 1'b1;
    @(posedge clk);
    #1;
    if (push) begin
      exp_t e;
      e.i0  = e0;
      e.i1  = e1;
      e.err = {slot_fault(a1), slot_fault(a0)};
      e.cyc = cyc + lat(d) - 1;
      sb[d].push_back(e);
    end
  endtask

  task automatic wait_ready(input int d);
    bit got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (resp[d].ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check_eq($sformatf("rdy_timeout%0d", d), 64'(resp[d].ready), 64'd1);
    req[d].valid = 1'b0;
  endtask

  task automatic fetch(input int d, input logic [31:0] a0, input logic [31:0] a1);
    issue(d, a0, a1, 1'b1, model_rd(a0), model_rd(a1));
    wait_ready(d);
  endtask

  task automatic bd_write(input logic [31:0] a, input logic [31:0] data);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = data;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    if (a < 32'(4 * DEPTH)) model_mem[a[11:2]] = data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < NDUT; d++) req[d] = '0;
    #2;
    for (int d = 0; d < NDUT; d++) begin
      check_eq($sformatf("rst_data%0d", d), {resp[d].instr0, resp[d].instr1}, 64'd0);
      check_eq($sformatf("rst_rdy%0d", d), 64'(resp[d].ready), 64'd0);
    end
    #10 reset_n = 1'b1;

    bd_write(32'h0, 32'h0050_0093);
    bd_write(32'h4, 32'h00A0_0113);
    bd_write(32'hFFC, 32'h1234_5678);

    // Basic, misaligned and out-of-range reads with fixed expectations
    issue(0, 32'h0, 32'h4, 1'b1, 32'h0050_0093, 32'h00A0_0113);
    wait_ready(0);
    issue(0, 32'h2, 32'h4, 1'b1, 32'h0000_0013, 32'h00A0_0113);
    wait_ready(0);
    issue(0, 32'hFFC, 32'h1000, 1'b1, 32'h1234_5678, 32'h0000_0013);
    wait_ready(0);

    // Out-of-range write must not alias onto word 0
    bd_write(32'h1000, 32'hBAD0_BAD0);
    issue(2, 32'h0, 32'h1000, 1'b1, 32'h0050_0093, 32'h0000_0013);
    wait_ready(2);
    issue(2, 32'h4, 32'h0, 1'b1, 32'h00A0_0113, 32'h0050_0093);
    wait_ready(2);

    // Flush and valid together in IDLE: flush wins, accept happens one edge later
    @(negedge clk);
    req[0].instr0 = 32'h4;
    req[0].instr1 = 32'h4;
    req[0].valid  = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    issue(0, 32'h4, 32'h4, 1'b1, 32'h00A0_0113, 32'h00A0_0113);
    wait_ready(0);

    // Flush in WAIT drops the request; a new one at the next cycle completes normally
    issue(1, 32'h0, 32'h4, 1'b0, '0, '0);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    issue(1, 32'h4, 32'h0, 1'b1, 32'h00A0_0113, 32'h0050_0093);
    wait_ready(1);

    // Flush in RESP gates ready in the same cycle
    issue(0, 32'h0, 32'h4, 1'b0, '0, '0);
    @(posedge clk);
    #1 check_eq("rdy_pre_flush", 64'(resp[0].ready), 64'd1);
    flush = 1'b1;
    #1 check_eq("flush_gate", 64'(resp[0].ready), 64'd0);
    @(negedge clk);
    req[0].valid = 1'b0;
    @(posedge clk);
    #1 flush = 1'b0;

    // Write during WAIT is visible, write during RESP is not
    issue(1, 32'h0, 32'h4, 1'b1, 32'hDEAD_BEEF, 32'h00A0_0113);
    bd_write(32'h0, 32'hDEAD_BEEF);
    wait_ready(1);
    issue(1, 32'h0, 32'h0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    @(posedge clk);
    @(posedge clk);
    bd_write(32'h0, 32'hCAFE_F00D);
    req[1].valid = 1'b0;
    issue(1, 32'h0, 32'h4, 1'b1, 32'hCAFE_F00D, 32'h00A0_0113);
    wait_ready(1);

    // Reset mid-WAIT: no response afterwards, fresh request has normal latency
    issue(1, 32'h0, 32'h4, 1'b0, '0, '0);
    #2 reset_n = 1'b0;
    req[1].valid = 1'b0;
    #1 check_eq("rst_wait_rdy", 64'(resp[1].ready), 64'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    fetch(1, 32'h4, 32'hFFC);

    // Reset mid-RESP drops ready asynchronously
    issue(0, 32'h0, 32'h4, 1'b0, '0, '0);
    @(posedge clk);
    #1 check_eq("rst_resp_pre", 64'(resp[0].ready), 64'd1);
    #1 reset_n = 1'b0;
    req[0].valid = 1'b0;
    #1 check_eq("rst_resp_rdy", 64'(resp[0].ready), 64'd0);
    check_eq("rst_resp_data", {resp[0].instr0, resp[0].instr1}, 64'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    fetch(0, 32'h0, 32'h4);

    // Random independent slot pairs across all three latencies
    for (int w = 0; w < 16; w++) bd_write(32'(w * 4), $urandom);
    for (int n = 0; n < 24; n++) begin
      logic [31:0] a [2];
      for (int s = 0; s < 2; s++) begin
        a[s] = 32'($urandom_range(0, 15) * 4);
        case ($urandom_range(0, 7))
          0:       a[s] = a[s] | 32'($urandom_range(1, 3));
          1:       a[s] = a[s] + 32'h1000;
          2:       a[s] = 32'hFFFF_FFFC;
          default: ;
        endcase
      end
      fetch(int'($urandom_range(0, NDUT - 1)), a[0], a[1]);
    end

    repeat (6) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) check_eq($sformatf("sb_empty%0d", d), 64'(sb[d].size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
